msk_hpc3_rnd_source: RTL



---
 rtl/msk_hpc3_rnd_source_if.sv | 24 ++
 rtl/msk_hpc3_rnd_source.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/msk_hpc3_rnd_source_if.sv
// msk_hpc3_rnd_source_if: seed-beat input and randomness-word output bundle
// for the HPC3 fresh-randomness source. The master modport is the source
// itself; the slave modport is the surrounding seeder/consumer side.
interface msk_hpc3_rnd_source_if #(
  parameter int RND_W = 2
);
  logic [31:0]      seed_data;
  logic             seed_valid;
  logic             seed_ready;
  logic [RND_W-1:0] rnd;
  logic             rnd_valid;
  logic             rnd_ready;
  logic             reseed_req;

  modport master (
    input  seed_data, seed_valid, rnd_ready,
    output seed_ready, rnd, rnd_valid, reseed_req
  );

  modport slave (
    output seed_data, seed_valid, rnd_ready,
    input  seed_ready, rnd, rnd_valid, reseed_req
  );
endinterface

// File: rtl/msk_hpc3_rnd_source.sv
// msk_hpc3_rnd_source: 128-bit Fibonacci LFSR (taps 127,125,100,98) that is
// seeded by four 32-bit beats, warmed up for WARMUP_CYC advances and then
// delivers RND_W fresh bits per consumed word to the HPC3 gadget pipeline.
// One advance of the state is RND_W chained single steps; rnd[k] is the
// feedback bit of step k. An all-zero seed is replaced by 1 so the LFSR
// never locks up.
// Optional automatic reseed request: define MSK_HPC3_RND_RESEED_EN.
module msk_hpc3_rnd_source #(
  parameter int d             = 2,
  parameter int RND_W         = d * (d - 1),
  parameter int WARMUP_CYC    = 16,
  parameter int RESEED_PERIOD = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  msk_hpc3_rnd_source_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WARMUP,
    RUN
  } state_e;

  localparam int WARM_W = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
  localparam logic [WARM_W-1:0] WARM_LAST =
    WARM_W'((WARMUP_CYC > 0) ? WARMUP_CYC - 1 : 0);

  // Reject configurations outside the supported range at elaboration
  if (RND_W < 1 || RND_W > 128 || RESEED_PERIOD < 1) begin : g_cfg_check
    $error("msk_hpc3_rnd_source: RND_W must be 1..128 and RESEED_PERIOD >= 1");
  end

  state_e              state_q, state_d;
  logic [127:0]        s_q, s_d;
  logic [95:0]         seed_buf_q, seed_buf_d;
  logic [1:0]          beat_q, beat_d;
  logic [WARM_W-1:0]   warm_q, warm_d;
  logic                rnd_valid_q, valid_d;

  logic [127:0]        chain;
  logic [127:0]        s_adv;
  logic [RND_W-1:0]    rnd_word;
  logic [127:0]        seed_word;
  logic                seed_ready;
  logic                seed_fire;
  logic                rnd_fire;

  assign seed_ready = (state_q != WARMUP);
  assign seed_fire  = bus.seed_valid && seed_ready;
  assign rnd_fire   = rnd_valid_q && bus.rnd_ready;
  assign seed_word  = {bus.seed_data, seed_buf_q};

  assign bus.seed_ready = seed_ready;
  assign bus.rnd        = rnd_word;
  assign bus.rnd_valid  = rnd_valid_q;

  // Unroll RND_W LFSR steps from the registered state, collecting feedback bits
  always_comb begin
    chain    = s_q;
    rnd_word = '0;
    for (int k = 0; k < RND_W; k++) begin
      rnd_word[k] = chain[127] ^ chain[125] ^ chain[100] ^ chain[98];
      chain       = {chain[126:0], rnd_word[k]};
    end
    s_adv = chain;
  end

  // Seeding / warm-up / run sequencing and LFSR state update
  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    seed_buf_d = seed_buf_q;
    beat_d     = beat_q;
    warm_d     = warm_q;

    if (rnd_fire) begin
      s_d = s_adv;
    end

    case (state_q)
      IDLE: begin
        if (seed_fire) begin
          seed_buf_d[31:0] = bus.seed_data;
          beat_d           = 2'd1;
          state_d          = LOAD;
        end
      end

      LOAD: begin
        if (seed_fire) begin
          case (beat_q)
            2'd1: begin
              seed_buf_d[63:32] = bus.seed_data;
              beat_d            = 2'd2;
            end
            2'd2: begin
              seed_buf_d[95:64] = bus.seed_data;
              beat_d            = 2'd3;
            end
            default: begin
              s_d     = (seed_word == '0) ? 128'h1 : seed_word;
              beat_d  = 2'd0;
              warm_d  = '0;
              state_d = (WARMUP_CYC == 0) ? RUN : WARMUP;
            end
          endcase
        end
      end

      WARMUP: begin
        s_d    = s_adv;
        warm_d = warm_q + WARM_W'(1);
        if (warm_q == WARM_LAST) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (seed_fire) begin
          seed_buf_d[31:0] = bus.seed_data;
          beat_d           = 2'd1;
          state_d          = LOAD;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef MSK_HPC3_RND_RESEED_EN
  localparam int WORD_W = $clog2(RESEED_PERIOD + 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(RESEED_PERIOD - 1);

  logic [WORD_W-1:0] word_q, word_d;
  logic              reseed_q, reseed_d;

  // Count words delivered in RUN and request a reseed once the period is used up
  always_comb begin
    word_d   = word_q;
    reseed_d = reseed_q;
    if ((state_q != RUN) && (state_d == RUN)) begin
      word_d = '0;
    end else if (rnd_fire) begin
      word_d = word_q + WORD_W'(1);
    end
    if (seed_fire) begin
      reseed_d = 1'b0;
    end else if (rnd_fire && (word_q == WORD_LAST)) begin
      reseed_d = 1'b1;
    end
  end

  // Word counter and reseed request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q   <= '0;
      reseed_q <= 1'b0;
    end else begin
      word_q   <= word_d;
      reseed_q <= reseed_d;
    end
  end

  assign valid_d        = (state_d == RUN) && !reseed_d;
  assign bus.reseed_req = reseed_q;
`else
  assign valid_d        = (state_d == RUN);
  assign bus.reseed_req = 1'b0;
`endif

  // State, seed buffer, counters and registered output-valid decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s_q         <= '0;
      seed_buf_q  <= '0;
      beat_q      <= '0;
      warm_q      <= '0;
      rnd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      seed_buf_q  <= seed_buf_d;
      beat_q      <= beat_d;
      warm_q      <= warm_d;
      rnd_valid_q <= valid_d;
    end
  end

endmodule
